spi_register_master: RTL

- SPI initiator that drives the picoview register interface from the other end of the link.
- Issues one register transaction per request:
  - 8-bit command: bit 7 = write, bits 6:0 = register number.
  - Followed by a 32-bit data word.
- Captures the 32-bit word returned by the target during the data phase.
- Used on test/bring-up FPGAs and in benches as the host-side model of the RPi, feeding a synchronizer-equipped simple SPI target.

---
 rtl/spi_register_master.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/spi_register_master.sv
// rtl/spi_register_master.sv - SPI mode-0 initiator issuing 8-bit command + 32-bit data register frames
module spi_register_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_write,
    input  logic [6:0]  target_register,
    input  logic [31:0] write_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] read_data,
    output logic        sck,
    output logic        sdo,
    input  logic        sdi,
    output logic        cs
);

    // Half-period counter counts down, so it only needs to hold CLK_DIV-1.
    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HW-1:0] HC_LOAD = HW'(CLK_DIV - 1);

    // One shared phase counter serves SETUP, HOLD and GAP.
    localparam int CMAX_SH = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CMAX    = (CMAX_SH > CS_GAP) ? CMAX_SH : CS_GAP;
    localparam int CW      = $clog2(CMAX + 1);
    localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP);
    localparam logic [CW-1:0] HOLD_END  = CW'(CS_HOLD);
    localparam logic [CW-1:0] GAP_END   = CW'(CS_GAP);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hc;
    logic [5:0]    bit_cnt;
    logic [39:0]   tx;
    // Only the last 32 sampled bits survive; command-byte samples shift out the top.
    logic [31:0]   rx;

    // Frame sequencer: owns every output register and the shift registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hc        <= '0;
            bit_cnt   <= '0;
            tx        <= '0;
            rx        <= '0;
            cs        <= 1'b1;
            sck       <= 1'b0;
            sdo       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            read_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx    <= {is_write, target_register, write_data};
                        cnt   <= '0;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    // First SETUP cycle drops cs and presents the command MSB.
                    if (cnt == '0) begin
                        cs   <= 1'b0;
                        busy <= 1'b1;
                        sdo  <= tx[39];
                    end
                    if (cnt == SETUP_END) begin
                        hc      <= HC_LOAD;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                SHIFT: begin
                    if (hc != '0) begin
                        hc <= hc - 1'b1;
                    end else begin
                        hc <= HC_LOAD;
                        if (!sck) begin
                            sck <= 1'b1;
                            rx  <= {rx[30:0], sdi};
                        end else begin
                            sck <= 1'b0;
                            if (bit_cnt == 6'd39) begin
                                cnt   <= CNT_ONE;
                                state <= HOLD;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                                sdo     <= tx[38];
                                tx      <= {tx[38:0], 1'b0};
                            end
                        end
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_END) begin
                        cs        <= 1'b1;
                        done      <= 1'b1;
                        read_data <= rx;
                        cnt       <= CNT_ONE;
                        state     <= GAP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                GAP: begin
                    // busy drops here; a pending start is taken on this same edge.
                    if (cnt == GAP_END) begin
                        busy <= 1'b0;
                        if (start) begin
                            tx    <= {is_write, target_register, write_data};
                            cnt   <= '0;
                            state <= SETUP;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
